// File: rtl/rand_range_picker.sv
// Bounded random value picker.
// Draws bytes from an external LFSR generator, masks them down to the
// smallest all-ones range covering the requested limit, and rejects
// samples that fall outside 0..limit-1. After MAX_TRIES rejections the
// last sample is folded into range by subtracting the limit.
module rand_range_picker #(
    parameter int MAX_TRIES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] limit,
    output logic       give_random,
    input  logic [7:0] rnd,
    output logic [7:0] value,
    output logic       valid,
    input  logic       ack,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [7:0] LAST_TRY = 8'(MAX_TRIES - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] lim;
    logic [7:0] mask;
    logic [7:0] tries;

    logic [7:0] span;
    logic [7:0] fill1;
    logic [7:0] fill2;
    logic [7:0] mask_new;
    logic [7:0] m;
    logic       hit;
    logic       last;
    logic       accept;

    // Smear the highest set bit of limit-1 downwards to form the mask,
    // and evaluate the current sample against the captured bound.
    always_comb begin
        span     = limit - 8'd1;
        fill1    = span | (span >> 1);
        fill2    = fill1 | (fill1 >> 2);
        mask_new = fill2 | (fill2 >> 4);
        m        = rnd & mask;
        hit      = (m < lim);
        last     = (tries == LAST_TRY);
        accept   = start && (limit != 8'd0);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_next  = state;
        give_random = 1'b0;
        valid       = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                give_random = 1'b1;
                state_next  = SAMPLE;
            end
            SAMPLE: begin
                if (hit || last) begin
                    state_next = DONE;
                end else begin
                    state_next = REQ;
                end
            end
            DONE: begin
                valid = 1'b1;
                if (ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture, retry counting, result registration and error pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            lim   <= '0;
            mask  <= '0;
            tries <= '0;
            value <= '0;
            err   <= 1'b0;
        end else begin
            err <= (state == IDLE) && start && (limit == 8'd0);
            case (state)
                IDLE: begin
                    if (accept) begin
                        lim   <= limit;
                        mask  <= mask_new;
                        tries <= '0;
                    end
                end
                SAMPLE: begin
                    if (hit) begin
                        value <= m;
                    end else if (last) begin
                        value <= m - lim;
                    end else begin
                        tries <= tries + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rand_range_picker.sv
// Self-checking bench for rand_range_picker: directed scenarios plus a
// sweep over every non-zero limit, with a generator model feeding rnd.
module tb_rand_range_picker;

    localparam int MT = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] limit = '0;
    logic       give_random;
    logic [7:0] rnd   = '0;
    logic [7:0] value;
    logic       valid;
    logic       ack   = 1'b0;
    logic       busy;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] dir_q[$];

    rand_range_picker #(.MAX_TRIES(MT)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .limit      (limit),
        .give_random(give_random),
        .rnd        (rnd),
        .value      (value),
        .valid      (valid),
        .ack        (ack),
        .busy       (busy),
        .err        (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One full request: the reference model decides, from the rnd bytes it
    // will hand out, how many draws are needed and what the result must be.
    task automatic do_op(input logic [7:0] lim_in, input logic perturb);
        logic [7:0] seq[$];
        int         p;
        int         mk;
        int         mv;
        int         exp_tries;
        int         exp_val;
        int         cyc;
        int         pulses;
        logic       got;
        seq = {};
        for (int i = 0; i < MT; i++) begin
            if (dir_q.size() > 0) seq.push_back(dir_q.pop_front());
            else seq.push_back(8'($urandom));
        end
        p = 1;
        while (p < int'(lim_in)) p = p * 2;
        mk = p - 1;
        exp_tries = MT;
        exp_val   = 0;
        for (int i = 0; i < MT; i++) begin
            mv = int'(seq[i]) & mk;
            if (mv < int'(lim_in)) begin
                exp_val   = mv;
                exp_tries = i + 1;
                break;
            end
            if (i == MT - 1) exp_val = mv - int'(lim_in);
        end

        start = 1'b1;
        limit = lim_in;
        step();
        start  = 1'b0;
        cyc    = 1;
        pulses = 0;
        got    = 1'b0;
        while (cyc <= 2 * MT + 3) begin
            if (valid) begin
                got = 1'b1;
                break;
            end
            check("busy_during_op", {31'd0, busy}, 32'd1);
            if (give_random) begin
                if (pulses < MT) rnd = seq[pulses];
                pulses++;
            end
            if (perturb) begin
                start = 1'($urandom_range(0, 1));
                limit = 8'($urandom);
            end
            step();
            cyc++;
        end
        start = 1'b0;
        check("valid_seen", {31'd0, got}, 32'd1);
        check("latency", cyc, 2 * exp_tries + 1);
        check("rnd_pulses", pulses, exp_tries);
        check("value", {24'd0, value}, exp_val);
        check("value_in_range", {31'd0, (value < lim_in)}, 32'd1);
        repeat (2) begin
            step();
            check("valid_held", {31'd0, valid}, 32'd1);
            check("value_stable", {24'd0, value}, exp_val);
            check("no_pulse_done", {31'd0, give_random}, 32'd0);
        end
        ack   = 1'b1;
        start = perturb;
        step();
        ack   = 1'b0;
        start = 1'b0;
        check("valid_after_ack", {31'd0, valid}, 32'd0);
        check("idle_after_ack", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // Reset state.
        reset = 1'b0;
        step();
        step();
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_give", {31'd0, give_random}, 32'd0);
        check("rst_value", {24'd0, value}, 32'd0);
        reset = 1'b1;

        // First-sample hit.
        dir_q = {8'h35};
        do_op(8'd10, 1'b0);
        // Two rejections, then a hit.
        dir_q = {8'h0C, 8'h0E, 8'h03};
        do_op(8'd10, 1'b0);
        // Every draw rejected: fallback subtraction.
        dir_q = {8'h07, 8'h07, 8'h07, 8'h07};
        do_op(8'd5, 1'b0);

        // Zero limit: error pulse only.
        start = 1'b1;
        limit = 8'd0;
        step();
        start = 1'b0;
        check("err_pulse", {31'd0, err}, 32'd1);
        check("err_not_busy", {31'd0, busy}, 32'd0);
        check("err_no_give", {31'd0, give_random}, 32'd0);
        check("err_no_valid", {31'd0, valid}, 32'd0);
        step();
        check("err_one_cycle", {31'd0, err}, 32'd0);
        check("err_still_idle", {31'd0, busy}, 32'd0);

        // Limit of one always gives zero.
        dir_q = {8'hFF};
        do_op(8'd1, 1'b0);

        // Reset during SAMPLE (previous value 5 must be cleared).
        dir_q = {8'h35};
        do_op(8'd10, 1'b0);
        start = 1'b1;
        limit = 8'd10;
        step();
        start = 1'b0;
        check("rq_give", {31'd0, give_random}, 32'd1);
        rnd = 8'h35;
        step();
        reset = 1'b0;
        step();
        check("rs_valid", {31'd0, valid}, 32'd0);
        check("rs_busy", {31'd0, busy}, 32'd0);
        check("rs_value", {24'd0, value}, 32'd0);
        check("rs_give", {31'd0, give_random}, 32'd0);
        reset = 1'b1;
        dir_q = {8'h0C, 8'h09};
        do_op(8'd10, 1'b0);

        // Reset during DONE.
        start = 1'b1;
        limit = 8'd10;
        step();
        start = 1'b0;
        rnd   = 8'h35;
        step();
        step();
        check("rd_valid_before", {31'd0, valid}, 32'd1);
        check("rd_value_before", {24'd0, value}, 32'd5);
        reset = 1'b0;
        step();
        check("rd_valid", {31'd0, valid}, 32'd0);
        check("rd_busy", {31'd0, busy}, 32'd0);
        check("rd_value", {24'd0, value}, 32'd0);
        reset = 1'b1;
        dir_q = {8'h02};
        do_op(8'd3, 1'b0);

        // Start and limit disturbed mid-operation.
        dir_q = {8'h0F, 8'h0B, 8'h04};
        do_op(8'd9, 1'b1);
        for (int i = 0; i < 6; i++) do_op(8'($urandom_range(1, 255)), 1'b1);

        // Sweep every non-zero limit with random draws.
        for (int l = 1; l <= 255; l++) do_op(8'(l), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rand_range_picker.md
RAND_RANGE_PICKER -- requirements
Module: rand_range_picker

Interface
REQ-001 Parameter MAX_TRIES, default 16, SHALL set the number of rejected samples (2..255) before the fallback value is used.
REQ-002 clock  input  1  SHALL be the system clock; all state changes on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 start  input  1  SHALL request one bounded random value; it is honoured only in IDLE.
REQ-005 limit  input  8  SHALL give the exclusive upper bound; it is captured on an accepted start.
REQ-006 give_random  output  1  SHALL be the one-cycle request pulse to the LFSR generator.
REQ-007 rnd  input  8  SHALL carry the generator's random byte; it is valid in the cycle after give_random.
REQ-008 value  output  8  SHALL carry the result, in range 0..limit-1.
REQ-009 valid  output  1  SHALL indicate that value is valid, held until ack.
REQ-010 ack  input  1  SHALL be the consumer acknowledge for value.
REQ-011 busy  output  1  SHALL be high in every state except IDLE.
REQ-012 err  output  1  SHALL pulse for one cycle when start is accepted with limit==0.

Function
REQ-013 The FSM SHALL have states IDLE, REQ, SAMPLE and DONE.
REQ-014 IDLE->REQ SHALL occur on start=1 with limit!=0; in the same edge the block SHALL latch lim=limit, set mask to the smallest (2^k-1) with mask>=lim-1 (lim=1 -> mask=0), and clear tries to 0.
REQ-015 On start=1 with limit==0 in IDLE, the block SHALL assert err for the next cycle only, remain in IDLE and leave valid low.
REQ-016 In REQ, give_random SHALL be 1 for exactly that cycle, and the FSM SHALL then go to SAMPLE; give_random SHALL be 0 in every other state.
REQ-017 In SAMPLE, the block SHALL compute m=rnd&mask; if m<lim it SHALL register value=m and go to DONE.
REQ-018 In SAMPLE, if m>=lim and tries<MAX_TRIES-1, the block SHALL increment tries and return to REQ.
REQ-019 In SAMPLE, if m>=lim and tries==MAX_TRIES-1, the block SHALL register value=m-lim (always <lim, since mask<2*lim) and go to DONE.
REQ-020 DONE SHALL hold valid=1 and a stable value; ack=1 SHALL move the FSM to IDLE with valid=0 on the next cycle.
REQ-021 start SHALL be ignored outside IDLE; start and ack together in DONE SHALL perform only the ack.
REQ-022 limit changes after capture SHALL have no effect on the request in progress.
REQ-023 Best-case latency from start to valid SHALL be 3 cycles (REQ, SAMPLE, DONE); each rejection SHALL add 2 cycles; worst case SHALL be 1+2*MAX_TRIES cycles.
REQ-024 All comparisons and the subtraction SHALL be 8-bit unsigned; tries SHALL be 8 bits wide and SHALL never wrap.
REQ-025 limit=1 SHALL always yield value=0 on the first sample.

Reset
REQ-026 While reset=0 at a clock edge, the FSM SHALL go to IDLE with value=0, valid=0, busy=0, err=0, give_random=0, tries=0, lim=0 and mask=0.
REQ-027 An asserted reset SHALL abort an operation in any state, drop valid and any pending give_random on the next edge, and discard the outstanding request.
REQ-028 After reset is released, the block SHALL accept start on the first edge.

Verification
REQ-029 Scenario: limit=10, start; rnd=0x35 in SAMPLE (mask=0x0F, m=5) -> give_random one pulse, valid at cycle 3, value=5, held until ack, then IDLE.
REQ-030 Scenario: limit=10; rnd=0x0C, then 0x0E, then 0x03 -> two extra REQ pulses, value=3 at cycle 7.
REQ-031 Scenario: MAX_TRIES=4, limit=5 (mask=7); rnd always 0x07 -> 4 give_random pulses, value=2 (7-5) at cycle 9.
REQ-032 Scenario: start with limit=0 -> err high one cycle, busy stays 0, no give_random; start with limit=1, rnd=0xFF -> value=0.
REQ-033 Scenario: reset=0 asserted during SAMPLE and during DONE -> next cycle valid=0, busy=0, value=0; a new start is then served normally.
REQ-034 Scenario: start pulsed while busy and limit changed mid-operation -> no second request is queued and the result uses the captured limit; exhaustive bench over limit=1..255 with a random rnd source checks value<limit on every result.
